// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ACCESS_CYCLES_DEF = 5;
    localparam int CNT_W             = 4;

    // Counter preload: the accept cycle and the commit cycle are both part of
    // the BUSYWAIT window, so the counter only covers the cycles in between.
    function automatic logic [CNT_W-1:0] cnt_preload(input int access_cycles);
        return CNT_W'(access_cycles - 2);
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - CPU load/store port with READ/WRITE/BUSYWAIT handshake
interface data_memory_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              READ;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDRESS;
    logic [DATA_W-1:0] WRITEDATA;
    logic [DATA_W-1:0] READDATA;
    logic              BUSYWAIT;

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA,
        input  READDATA, BUSYWAIT
    );

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA,
        output READDATA, BUSYWAIT
    );
endinterface

// File: rtl/dmem_access_timer.sv
// rtl/dmem_access_timer.sv - loadable down-counter timing one memory access
module dmem_access_timer
    import dmem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - fixed-latency byte memory on the CPU load/store port (option: DMEM_RESET_CLEAR_EN)
module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
)(
    input  logic          CLK,
    input  logic          RESET,
    data_memory_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              commit;
    logic              cnt_zero;

    logic              req_write;
    logic              req_read;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [DATA_W-1:0] rdata_q;

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept in IDLE, commit when the timer expires, and a single
    // DONE slot in which requests are ignored so the CPU can drop them.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.READ || bus.WRITE) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_zero) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dmem_access_timer u_timer (
        .clk      (CLK),
        .rst_n    (RESET),
        .load     (accept),
        .load_val (cnt_preload(ACCESS_CYCLES)),
        .dec      (state_q == BUSY),
        .zero     (cnt_zero)
    );

    // Request latch: the bus is only sampled at accept; READ+WRITE counts as a write.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            req_write <= 1'b0;
            req_read  <= 1'b0;
            req_addr  <= '0;
            req_data  <= '0;
        end else if (accept) begin
            req_write <= bus.WRITE;
            req_read  <= bus.READ && !bus.WRITE;
            req_addr  <= bus.ADDRESS;
            req_data  <= bus.WRITEDATA;
        end
    end

`ifdef DMEM_RESET_CLEAR_EN
    // Storage array, wiped to zero whenever RESET is asserted.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit && req_write) begin
            mem[req_addr] <= req_data;
        end
    end
`else
    // Storage array without reset so it can map onto block RAM; a reset
    // mid-access forces IDLE, so an aborted write never reaches commit.
    always_ff @(posedge CLK) begin
        if (commit && req_write) begin
            mem[req_addr] <= req_data;
        end
    end
`endif

    // Read result register: only a completed read updates it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rdata_q <= '0;
        end else if (commit && req_read) begin
            rdata_q <= mem[req_addr];
        end
    end

    assign bus.READDATA = rdata_q;
    assign bus.BUSYWAIT = RESET &&
                          (((state_q == IDLE) && (bus.READ || bus.WRITE)) ||
                           (state_q == BUSY));

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory against a behavioural model
module tb_data_memory;

    localparam int AC = 5;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    always #5 CLK = ~CLK;

    data_memory_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    data_memory #(
        .ADDR_W        (8),
        .DATA_W        (8),
        .ACCESS_CYCLES (AC)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem   [256];
    bit         ref_known [256];
    logic [7:0] ref_rdata;
    bit         ref_rdata_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ref_rdata       = 8'h00;
        ref_rdata_known = 1'b1;
`ifdef DMEM_RESET_CLEAR_EN
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 8'h00;
            ref_known[i] = 1'b1;
        end
`endif
    endtask

    // One full access as the CPU performs it; starts and ends just after a rising edge.
    task automatic access(input bit rd, input bit wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input bit hold, input bit disturb);
        bus.READ      = rd;
        bus.WRITE     = wr;
        bus.ADDRESS   = addr;
        bus.WRITEDATA = wdata;
        for (int c = 0; c < AC; c++) begin
            @(negedge CLK);
            check($sformatf("busy_a%02h_c%0d", addr, c), bus.BUSYWAIT, 1);
            if (disturb && c == 2) begin
                bus.ADDRESS   = addr + 8'd1;
                bus.WRITEDATA = ~wdata;
            end
            @(posedge CLK);
            #1;
        end
        if (wr) begin
            ref_mem[addr]   = wdata;
            ref_known[addr] = 1'b1;
        end else if (rd) begin
            ref_rdata       = ref_mem[addr];
            ref_rdata_known = ref_known[addr];
        end
        @(negedge CLK);
        check($sformatf("done_busy_a%02h", addr), bus.BUSYWAIT, 0);
        if (ref_rdata_known) begin
            check($sformatf("readdata_a%02h", addr), bus.READDATA, ref_rdata);
        end
        @(posedge CLK);
        #1;
        if (!hold) begin
            bus.READ  = 1'b0;
            bus.WRITE = 1'b0;
            @(negedge CLK);
            check("idle_busy", bus.BUSYWAIT, 0);
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 8'h00;
            ref_known[i] = 1'b0;
        end
        bus.READ      = 1'b1;
        bus.WRITE     = 1'b1;
        bus.ADDRESS   = 8'h10;
        bus.WRITEDATA = 8'h00;
        #12;
        check("reset_busy", bus.BUSYWAIT, 0);
        check("reset_rdata", bus.READDATA, 0);
        @(negedge CLK);
        RESET     = 1'b1;
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;

        // Read straight after reset (checked only where memory is cleared).
        access(1, 0, 8'h10, 8'h00, 0, 0);

        // Write then read back, neighbour untouched.
        access(0, 1, 8'h3D, 8'h5A, 0, 0);
        access(0, 1, 8'h3C, 8'hA5, 0, 0);
        access(1, 0, 8'h3C, 8'h00, 0, 0);
        access(1, 0, 8'h3D, 8'h00, 0, 0);

        // Back-to-back reads with READ held across DONE.
        access(1, 0, 8'h3C, 8'h00, 1, 0);
        access(1, 0, 8'h3D, 8'h00, 1, 0);
        access(1, 0, 8'h3C, 8'h00, 0, 0);

        // Address and data changed during BUSY are ignored.
        access(0, 1, 8'h21, 8'h12, 0, 0);
        access(0, 1, 8'h20, 8'h77, 0, 1);
        access(1, 0, 8'h20, 8'h00, 0, 0);
        access(1, 0, 8'h21, 8'h00, 0, 0);

        // Reset in cycle 2 of a write aborts it.
        access(0, 1, 8'h08, 8'h3E, 0, 0);
        bus.READ      = 1'b0;
        bus.WRITE     = 1'b1;
        bus.ADDRESS   = 8'h08;
        bus.WRITEDATA = 8'h55;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            check($sformatf("rstw_busy_c%0d", c), bus.BUSYWAIT, 1);
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rstw_busy_drop", bus.BUSYWAIT, 0);
        check("rstw_rdata", bus.READDATA, 0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rstw_busy_held", bus.BUSYWAIT, 0);
        RESET     = 1'b1;
        bus.WRITE = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        access(1, 0, 8'h08, 8'h00, 0, 0);

        // READ and WRITE together behave as a write.
        access(0, 1, 8'h3C, 8'hA5, 0, 0);
        access(1, 0, 8'h3C, 8'h00, 0, 0);
        access(1, 1, 8'h40, 8'h99, 0, 0);
        access(1, 0, 8'h40, 8'h00, 0, 0);

        // Randomized traffic over a small address pool.
        for (int i = 0; i < 8; i++) begin
            access(0, 1, 8'h80 + 8'(i), 8'($urandom), 0, 0);
        end
        for (int n = 0; n < 30; n++) begin
            int         op;
            logic [7:0] a;
            op = int'($urandom_range(0, 2));
            a  = 8'h80 + 8'($urandom_range(0, 7));
            access(op != 1, op != 0, a, 8'($urandom), 1'($urandom_range(0, 1)), 0);
        end
        access(1, 0, 8'h80, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressed data memory that answers the CPU's load/store port: the responder end of the READ/WRITE/BUSYWAIT handshake the processor drives for memory instructions. It sits beside the cpu in the testbench top level and holds 256 × 8-bit words. Every access takes a fixed multi-cycle latency, and BUSYWAIT stalls the CPU for the whole of it.

## Interface
Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W words
- DATA_W, 8, word width
- ACCESS_CYCLES, 5, cycles BUSYWAIT stays high per access; legal range 2..16

Ports:
- CLK  input  1  single clock; all state changes on its rising edge
- RESET  input  1  asynchronous, active-low reset
- READ  input  1  load request, held by the CPU until BUSYWAIT is low
- WRITE  input  1  store request, held by the CPU until BUSYWAIT is low
- ADDRESS  input  ADDR_W  word address
- WRITEDATA  input  DATA_W  store data
- READDATA  output  DATA_W  load result, registered
- BUSYWAIT  output  1  stall request to the CPU

## Operation
- States:
  - IDLE: no access in progress.
  - BUSY: access in progress; 4-bit down-counter cnt running.
  - DONE: one-cycle completion slot that lets the CPU drop its request.
- BUSYWAIT is combinational: it is 1 when (IDLE and (READ or WRITE)) or BUSY. It is 0 in DONE.
- IDLE, with READ or WRITE sampled high at an edge:
  - Latch op, ADDRESS and WRITEDATA.
  - cnt ← ACCESS_CYCLES−2.
  - Go to BUSY.
- BUSY, cnt ≠ 0: cnt decrements each edge.
- BUSY, cnt = 0 at an edge:
  - Commit the access using the latched values: a write updates mem[addr]; a read loads READDATA ← mem[addr].
  - Go to DONE.
- DONE goes to IDLE unconditionally at the next edge. Requests are not sampled in DONE.
- READ and WRITE both high at accept: treated as a write. READDATA is unchanged.
- Changes to ADDRESS, WRITEDATA, READ or WRITE during BUSY or DONE are ignored; only the values latched at accept are used.
- READDATA holds the last completed read value until another read completes. Writes never disturb it.
- RESET low, at any time including mid-access:
  - State → IDLE, cnt → 0, READDATA → 0, latched request → 0.
  - An in-flight write is aborted and never committed.
  - BUSYWAIT is 0 while RESET is low, regardless of READ/WRITE.

## Timing
- The request first appears in cycle 0, with state IDLE.
- BUSYWAIT is high in cycles 0 .. ACCESS_CYCLES−1.
- The commit happens at the rising edge that ends cycle ACCESS_CYCLES−1.
- Cycle ACCESS_CYCLES is DONE: BUSYWAIT = 0, and READDATA is valid for a read.
- At the edge ending that DONE cycle the CPU advances PC and drops or changes the request.
- A new request is accepted at earliest in cycle ACCESS_CYCLES+1, giving a minimum issue interval of ACCESS_CYCLES+1 cycles.
- A write is visible to a read accepted in any later cycle (no bypass needed; the commit precedes that accept).
- Reset values: READDATA = 0, BUSYWAIT = 0, state = IDLE.

## Configuration
- DMEM_RESET_CLEAR_EN defined:
  - Asserting RESET also clears every memory word to 0 asynchronously.
  - Read of any never-written address after reset returns 0.
- DMEM_RESET_CLEAR_EN undefined:
  - Memory contents survive reset; only the control state and READDATA are reset.
  - Array initial contents are unspecified (X in simulation). This allows inference of block RAM.

## Structure
- Package dmem_pkg holds:
  - the state enum {IDLE, BUSY, DONE}
  - the default ACCESS_CYCLES
  - the counter width constant CNT_W = 4
- One sub-module, dmem_access_timer:
  - loadable down-counter with load, dec and zero flag
  - instantiated once for cnt
- The memory array, request latch and FSM live in data_memory.

## Test plan
- Reset then read: RESET pulsed low, then READ of address 0x10 with DMEM_RESET_CLEAR_EN defined → BUSYWAIT high for exactly 5 cycles, READDATA = 0x00 in the DONE cycle.
- Write then read back: WRITE 0xA5 to 0x3C, then READ 0x3C → each access stalls 5 cycles; READDATA = 0xA5 in the DONE cycle of the read. A read of 0x3D still returns its prior value.
- Back-to-back accesses: READ held continuously across DONE → no second accept during DONE; the next accept comes at cycle 6; BUSYWAIT is low for exactly one cycle between accesses.
- Mid-access disturbance: ADDRESS changed from 0x20 to 0x21 and WRITEDATA changed during BUSY of a write of 0x77 → mem[0x20] = 0x77 and mem[0x21] is unchanged.
- Reset mid-write: RESET asserted in cycle 2 of a WRITE 0x55 to 0x08 → BUSYWAIT drops immediately, state is IDLE; with DMEM_RESET_CLEAR_EN undefined, a later read of 0x08 returns the pre-write value.
- Simultaneous READ and WRITE: 0x99 to 0x40 → treated as a write; READDATA unchanged; a subsequent read of 0x40 returns 0x99.
